// File: rtl/deadtime_controller.sv
// Multi-channel dead-time controller: accepted triggers blank a channel's counter
// enable for D cycles, with optional global suspension, retrigger, veto and statistics.
module deadtime_controller #(
  parameter int N_CH           = 2,
  parameter int CNT_W          = 32,
  parameter int SUSPEND_CYCLES = 500_000_000,
  parameter int STAT_W         = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   trigger,
  input  logic              mode_global,
  input  logic              retrigger,
  input  logic              force_veto,
  input  logic              cfg_load,
  input  logic [CNT_W-1:0]  cfg_cycles,
  input  logic              stat_clr,
  output logic [N_CH-1:0]   enable_out,
  output logic              busy,
  output logic [STAT_W-1:0] accepted_count,
  output logic [STAT_W-1:0] lost_count
);

  // A zero dead time would never suspend anything, so it is stored as one cycle.
  localparam logic [CNT_W-1:0] D_RST = (SUSPEND_CYCLES < 1) ? CNT_W'(1) : CNT_W'(SUSPEND_CYCLES);

  logic [CNT_W-1:0]  d_q, d_d;
  logic [STAT_W-1:0] acc_q, acc_d;
  logic [STAT_W-1:0] lost_q, lost_d;

  logic [N_CH-1:0] idle;
  logic [N_CH-1:0] load;
  logic [N_CH-1:0] ch_accept;
  logic [N_CH-1:0] ch_reject;
  logic            all_idle;
  logic            any_trig;
  logic            g_accept;
  logic            acc_evt;
  logic            lost_evt;

  assign all_idle = &idle;
  assign any_trig = |trigger;

  always_comb begin
    ch_accept = trigger & ~{N_CH{force_veto}} & (idle | {N_CH{retrigger}});
    ch_reject = trigger & ~ch_accept;
    g_accept  = any_trig && !force_veto && (all_idle || retrigger);
    load      = '0;
    acc_evt   = 1'b0;
    lost_evt  = 1'b0;
    if (mode_global) begin
      // The whole trigger vector is one event judged against the joint idle state.
      load     = {N_CH{g_accept}};
      acc_evt  = g_accept;
      lost_evt = any_trig && !g_accept;
    end else begin
      load     = ch_accept;
      acc_evt  = |ch_accept;
      lost_evt = |ch_reject;
    end
  end

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : gen_ch
      logic [CNT_W-1:0] timer_q, timer_d;

      assign idle[gi] = (timer_q == '0);

      always_comb begin
        timer_d = timer_q;
        if (load[gi]) begin
          timer_d = d_q;
        end else if (!idle[gi]) begin
          timer_d = timer_q - CNT_W'(1);
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          timer_q <= '0;
        end else begin
          timer_q <= timer_d;
        end
      end
    end
  endgenerate

  always_comb begin
    d_d = d_q;
    if (cfg_load) begin
      d_d = (cfg_cycles == '0) ? CNT_W'(1) : cfg_cycles;
    end

    acc_d = acc_q;
    if (stat_clr) begin
      acc_d = '0;
    end else if (acc_evt && (acc_q != '1)) begin
      acc_d = acc_q + STAT_W'(1);
    end

    lost_d = lost_q;
    if (stat_clr) begin
      lost_d = '0;
    end else if (lost_evt && (lost_q != '1)) begin
      lost_d = lost_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_q    <= D_RST;
      acc_q  <= '0;
      lost_q <= '0;
    end else begin
      d_q    <= d_d;
      acc_q  <= acc_d;
      lost_q <= lost_d;
    end
  end

  assign enable_out     = idle & ~{N_CH{force_veto}};
  assign busy           = !all_idle || force_veto;
  assign accepted_count = acc_q;
  assign lost_count     = lost_q;

endmodule

// File: tb/tb_deadtime_controller.sv
// Table-driven bench for deadtime_controller with a scoreboard of expected outputs,
// plus hand-written reset-mid-suspension and latency sequences.
module tb_deadtime_controller;

  localparam int N_CH   = 2;
  localparam int CNT_W  = 16;
  localparam int STAT_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [N_CH-1:0]   trigger;
  logic              mode_global;
  logic              retrigger;
  logic              force_veto;
  logic              cfg_load;
  logic [CNT_W-1:0]  cfg_cycles;
  logic              stat_clr;
  logic [N_CH-1:0]   enable_out;
  logic              busy;
  logic [STAT_W-1:0] accepted_count;
  logic [STAT_W-1:0] lost_count;

  deadtime_controller #(
    .N_CH(N_CH), .CNT_W(CNT_W), .SUSPEND_CYCLES(5), .STAT_W(STAT_W)
  ) dut (
    .clk(clk), .rst(rst), .trigger(trigger), .mode_global(mode_global),
    .retrigger(retrigger), .force_veto(force_veto), .cfg_load(cfg_load),
    .cfg_cycles(cfg_cycles), .stat_clr(stat_clr), .enable_out(enable_out),
    .busy(busy), .accepted_count(accepted_count), .lost_count(lost_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  trig;
    logic        mg, rt, veto, ld;
    logic [15:0] cyc;
    logic        clr, rs;
    logic [1:0]  en;
    logic        busy;
    logic [3:0]  acc, lost;
  } vec_t;

  typedef struct {
    int         idx;
    logic [1:0] en;
    logic       busy;
    logic [3:0] acc, lost;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   acc_e, lost_e, low_cnt;

  task automatic row(input logic [1:0] trig, input logic mg, input logic rt, input logic veto,
                     input logic ld, input logic [15:0] cyc, input logic clr, input logic rs,
                     input logic [1:0] en, input logic bsy, input logic [3:0] acc,
                     input logic [3:0] lost);
    vec_t v;
    v.trig = trig; v.mg = mg; v.rt = rt; v.veto = veto; v.ld = ld; v.cyc = cyc;
    v.clr = clr; v.rs = rs; v.en = en; v.busy = bsy; v.acc = acc; v.lost = lost;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s (vec %0d): got %0d, expected %0d", name, idx, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; trigger = '0; mode_global = 1'b0; retrigger = 1'b0; force_veto = 1'b0;
    cfg_load = 1'b0; cfg_cycles = '0; stat_clr = 1'b0;

    //  trig   mg rt vt ld cyc  clr rs  en     busy acc lost
    row(2'b00, 0, 0, 0, 0, 0,   0, 1,  2'b11, 0,   0,  0);   // reset
    row(2'b00, 0, 0, 0, 0, 0,   0, 0,  2'b11, 0,   0,  0);
    row(2'b01, 0, 0, 0, 0, 0,   0, 0,  2'b10, 1,   1,  0);   // accept, D=5
    repeat (2) row(2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b10, 1, 1, 0);
    row(2'b01, 0, 0, 0, 0, 0,   0, 0,  2'b10, 1,   1,  1);   // rejected, no extension
    row(2'b00, 0, 0, 0, 0, 0,   0, 0,  2'b10, 1,   1,  1);
    row(2'b00, 0, 0, 0, 0, 0,   0, 0,  2'b11, 0,   1,  1);   // re-enable after 5
    row(2'b01, 0, 1, 0, 0, 0,   0, 0,  2'b10, 1,   2,  1);   // retrigger section
    repeat (2) row(2'b00, 0, 1, 0, 0, 0, 0, 0, 2'b10, 1, 2, 1);
    row(2'b01, 0, 1, 0, 0, 0,   0, 0,  2'b10, 1,   3,  1);   // reload while suspended
    repeat (4) row(2'b00, 0, 1, 0, 0, 0, 0, 0, 2'b10, 1, 3, 1);
    row(2'b00, 0, 1, 0, 0, 0,   0, 0,  2'b11, 0,   3,  1);
    row(2'b10, 1, 0, 0, 0, 0,   0, 0,  2'b00, 1,   4,  1);   // global mode
    repeat (4) row(2'b00, 1, 0, 0, 0, 0, 0, 0, 2'b00, 1, 4, 1);
    row(2'b00, 1, 0, 0, 0, 0,   0, 0,  2'b11, 0,   4,  1);
    row(2'b11, 1, 0, 0, 0, 0,   0, 0,  2'b00, 1,   5,  1);   // both bits count once
    row(2'b11, 1, 0, 0, 0, 0,   0, 0,  2'b00, 1,   5,  2);   // both bits rejected once
    repeat (3) row(2'b00, 1, 0, 0, 0, 0, 0, 0, 2'b00, 1, 5, 2);
    row(2'b01, 1, 0, 0, 0, 0,   0, 0,  2'b11, 0,   5,  3);   // trigger at timer==1 rejected
    row(2'b01, 1, 0, 0, 0, 0,   0, 0,  2'b00, 1,   6,  3);   // accepted right after re-enable
    repeat (4) row(2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 6, 3); // mode change mid-run
    row(2'b00, 0, 0, 0, 0, 0,   0, 0,  2'b11, 0,   6,  3);
    row(2'b00, 0, 0, 0, 0, 0,   1, 0,  2'b11, 0,   0,  0);   // stat_clr
    row(2'b00, 0, 0, 0, 1, 0,   0, 0,  2'b11, 0,   0,  0);   // cfg 0 -> D=1
    row(2'b10, 0, 0, 0, 0, 0,   0, 0,  2'b01, 1,   1,  0);
    row(2'b00, 0, 0, 0, 0, 0,   0, 0,  2'b11, 0,   1,  0);   // 1-cycle gap
    row(2'b01, 0, 0, 0, 1, 7,   0, 0,  2'b10, 1,   2,  0);   // load 7 + trigger: old D
    row(2'b00, 0, 0, 0, 0, 0,   0, 0,  2'b11, 0,   2,  0);
    row(2'b01, 0, 0, 0, 0, 0,   0, 0,  2'b10, 1,   3,  0);   // new D=7
    repeat (6) row(2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b10, 1, 3, 0);
    row(2'b00, 0, 0, 0, 0, 0,   0, 0,  2'b11, 0,   3,  0);
    row(2'b00, 0, 0, 0, 1, 5,   0, 0,  2'b11, 0,   3,  0);   // D=5
    row(2'b01, 0, 0, 1, 0, 0,   0, 0,  2'b00, 1,   3,  1);   // veto rejects
    row(2'b10, 0, 0, 1, 0, 0,   0, 0,  2'b00, 1,   3,  2);
    row(2'b11, 0, 0, 1, 0, 0,   0, 0,  2'b00, 1,   3,  3);
    row(2'b01, 0, 0, 1, 0, 0,   0, 0,  2'b00, 1,   3,  4);
    row(2'b00, 0, 0, 0, 0, 0,   0, 0,  2'b11, 0,   3,  4);   // nothing loaded
    row(2'b01, 0, 0, 0, 0, 0,   0, 0,  2'b10, 1,   4,  4);
    row(2'b00, 0, 0, 1, 0, 0,   0, 0,  2'b00, 1,   4,  4);   // veto, timer still counts
    row(2'b01, 0, 1, 1, 0, 0,   0, 0,  2'b00, 1,   4,  5);   // veto beats retrigger
    repeat (2) row(2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b10, 1, 4, 5);
    row(2'b00, 0, 0, 0, 0, 0,   0, 0,  2'b11, 0,   4,  5);
    row(2'b00, 0, 0, 0, 1, 3,   1, 0,  2'b11, 0,   0,  0);   // D=3, clear stats
    // Held trigger, D=3, no retrigger: one accept every 4 cycles, lost saturates at 15.
    for (int k = 1; k <= 24; k++) begin
      acc_e  = (k + 3) / 4;
      lost_e = k - acc_e;
      if (lost_e > 15) lost_e = 15;
      row(2'b01, 0, 0, 0, 0, 0, 0, 0, (k % 4 == 0) ? 2'b11 : 2'b10, (k % 4 != 0),
          4'(acc_e), 4'(lost_e));
    end
    row(2'b01, 0, 0, 0, 0, 0,   0, 0,  2'b10, 1,   7, 15);
    row(2'b01, 0, 0, 0, 0, 0,   1, 0,  2'b10, 1,   0,  0);   // clr beats reject
    row(2'b01, 0, 0, 0, 0, 0,   0, 0,  2'b10, 1,   0,  1);
    row(2'b00, 0, 0, 0, 0, 0,   0, 0,  2'b11, 0,   0,  1);

    for (int i = 0; i < vecs.size(); i++) begin
      exp_t e;
      trigger = vecs[i].trig; mode_global = vecs[i].mg; retrigger = vecs[i].rt;
      force_veto = vecs[i].veto; cfg_load = vecs[i].ld; cfg_cycles = vecs[i].cyc;
      stat_clr = vecs[i].clr; rst = vecs[i].rs;
      e.idx = i; e.en = vecs[i].en; e.busy = vecs[i].busy;
      e.acc = vecs[i].acc; e.lost = vecs[i].lost;
      sb.push_back(e);
      tick();
      e = sb.pop_front();
      $display("vec %0d: en=%b busy=%b acc=%0d lost=%0d", e.idx, enable_out, busy,
               accepted_count, lost_count);
      check("enable_out", e.idx, 32'(enable_out), 32'(e.en));
      check("busy", e.idx, 32'(busy), 32'(e.busy));
      check("accepted_count", e.idx, 32'(accepted_count), 32'(e.acc));
      check("lost_count", e.idx, 32'(lost_count), 32'(e.lost));
    end
    trigger = '0; mode_global = 1'b0; retrigger = 1'b0; force_veto = 1'b0;
    cfg_load = 1'b0; stat_clr = 1'b0; rst = 1'b0;

    // Reset in the middle of a long suspension.
    cfg_load = 1'b1; cfg_cycles = 16'd100;
    tick();
    cfg_load = 1'b0; trigger = 2'b01;
    tick();
    trigger = 2'b00;
    repeat (3) tick();
    $display("d100 run: en=%b busy=%b acc=%0d", enable_out, busy, accepted_count);
    check("d100_enable", -1, 32'(enable_out), 32'(2'b10));
    check("d100_accepted", -1, 32'(accepted_count), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    $display("after rst: en=%b busy=%b acc=%0d lost=%0d", enable_out, busy,
             accepted_count, lost_count);
    check("rst_enable", -1, 32'(enable_out), 32'(2'b11));
    check("rst_busy", -1, 32'(busy), 32'd0);
    check("rst_accepted", -1, 32'(accepted_count), 32'd0);
    check("rst_lost", -1, 32'(lost_count), 32'd0);

    // Dead time must be back at the reset value of 5 cycles.
    trigger = 2'b01;
    tick();
    trigger = 2'b00;
    low_cnt = 0;
    while (enable_out[0] == 1'b0 && low_cnt < 200) begin
      low_cnt++;
      tick();
    end
    $display("post-rst suspension: %0d cycles", low_cnt);
    check("rst_d_restored", -1, 32'(low_cnt), 32'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/deadtime_controller.md
# deadtime_controller

Multi-channel dead-time (suspension) controller for the muon lifetime front end. A trigger on a channel (typically a coincidence) disables that channel's counter enable for a programmable number of clock cycles. Optionally, a trigger suspends every channel at once. The block also supports retrigger extension, a global veto, and saturating accepted/lost trigger counters. It sits between the coincidence logic and the per-channel time counters.

## Interface
Parameters:
- N_CH, 2, number of channels (1..32)
- CNT_W, 32, dead-time timer width
- SUSPEND_CYCLES, 500_000_000, reset value of the dead-time register (5 s at 100 MHz); 0 is stored as 1
- STAT_W, 16, width of the accepted/lost counters

Ports:
- clk  in  1  system clock (100 MHz)
- rst  in  1  reset, synchronous and active-high
- trigger  in  N_CH  per-channel trigger, sampled high on each rising clk edge
- mode_global  in  1  1: any accepted trigger suspends all channels; 0: channels are independent
- retrigger  in  1  1: a trigger during suspension reloads that timer; 0: the trigger is rejected
- force_veto  in  1  forces all enables low and rejects all triggers
- cfg_load  in  1  loads cfg_cycles into the dead-time register D
- cfg_cycles  in  CNT_W  new dead-time length in cycles
- stat_clr  in  1  clears both statistics counters
- enable_out  out  N_CH  per-channel counter enable
- busy  out  1  high when any timer is nonzero or force_veto is high
- accepted_count  out  STAT_W  saturating count of cycles with at least one accepted trigger
- lost_count  out  STAT_W  saturating count of cycles with at least one rejected trigger

## Operation
- State per channel i: timer_i (CNT_W bits). The channel is idle when timer_i == 0 and suspended otherwise.
- Dead-time register D:
  - Reset value is max(SUSPEND_CYCLES, 1).
  - cfg_load stores max(cfg_cycles, 1).
  - A new D applies only to loads on later cycles. Running timers are never rescaled.
- Each cycle, every nonzero timer decrements by 1. A load overrides the decrement in the same cycle.
- enable_out[i] = (timer_i == 0) && !force_veto. It is decoded from registers only; there is no combinational path from trigger.
- Independent mode (mode_global = 0), for each i with trigger[i] high:
  - Channel idle and no veto: accepted; timer_i loads D.
  - Channel suspended and retrigger = 1: accepted; timer_i reloads D.
  - Channel suspended and retrigger = 0: rejected; timer unchanged.
- Global mode (mode_global = 1), any trigger bit high:
  - Evaluated as a single event against "all timers zero". The same accept/retrigger/reject rules apply.
  - On accept, all N_CH timers load D.
- While force_veto is high:
  - Every trigger is rejected.
  - Timers keep counting down.
  - enable_out is all zero.
- Statistics:
  - accepted_count increments by 1 per cycle with at least one accepted bit.
  - lost_count increments by 1 per cycle with at least one rejected bit.
  - Both counters saturate at all-ones.
  - stat_clr takes priority over increment in the same cycle; the counter becomes 0.
- Changing mode_global while busy affects only new triggers. Existing timers run to completion.

## Timing
- Reset values (rst dominates every other input):
  - all timers 0
  - enable_out all ones
  - busy 0
  - both counters 0
  - D = max(SUSPEND_CYCLES, 1)
- Latency: trigger accepted at edge t → enable_out low from t+1 for exactly D cycles → high at t+1+D.
- Trigger during the last suspended cycle (timer == 1) counts as "during suspension": it is rejected, or reloaded if retrigger = 1.
- A trigger in the cycle right after re-enable (timer == 0) is accepted.
- A held-high trigger with retrigger = 0 and D = 3 produces suspension blocks of 3 cycles with 1-cycle enable gaps. The lost count grows 3 per 4 cycles.
- cfg_load and trigger in the same cycle: the trigger uses the old D.
- rst asserted mid-suspension: enables return high on the next edge and the suspension is abandoned.
- busy follows timers combinationally: high from t+1 through the last suspended cycle.

## Test plan
- Basic suspension: N_CH=2, D=5 (SUSPEND_CYCLES=5), independent mode, pulse trigger[0] at cycle 10 → enable_out[0] low for cycles 11..15, high at 16; enable_out[1] stays high; accepted_count=1.
- No retrigger: retrigger=0, trigger[0] again at cycle 13 → no extension, lost_count=1, re-enable at 16. Retrigger: retrigger=1, same stimulus → re-enable at 19, accepted_count=2.
- Global mode: mode_global=1, pulse trigger[1] → both enables low for 5 cycles. A simultaneous trigger on both bits → accepted_count increments by 1, not 2.
- Config and boundary: cfg_load with cfg_cycles=0 → D=1, a trigger gives a 1-cycle gap. cfg_load of 7 in the same cycle as a trigger → that suspension lasts 1 cycle; the next one lasts 7.
- Veto and stats: force_veto high for 4 cycles with trigger pulses → enables low throughout, lost_count +4, no timer loaded. With STAT_W=4, drive 20 rejects → lost_count holds at 15. stat_clr concurrent with a reject → lost_count=0.
- Reset mid-operation: rst during a D=100 suspension → next edge: enable_out=all ones, busy=0, counters 0, D restored to SUSPEND_CYCLES.
